// File: rtl/serial_half_sub_nand.sv
// Bit-serial unsigned subtractor: one NAND-built full-subtractor cell processes
// one bit per clock, LSB first, under a start/busy/done handshake.
module serial_half_sub_nand #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic nand2(input logic x, input logic y);
        return ~(x & y);
    endfunction

    // Half-subtractor from NANDs only: returns {borrow = ~x & y, diff = x ^ y}.
    function automatic logic [1:0] half_sub_nand(input logic x, input logic y);
        logic n_xy;
        logic n_x;
        logic n_bor;
        n_xy  = nand2(x, y);
        n_x   = nand2(x, x);
        n_bor = nand2(n_x, y);
        return {nand2(n_bor, n_bor), nand2(nand2(x, n_xy), nand2(y, n_xy))};
    endfunction

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_br;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bo;
    logic [1:0]         w_hs1;
    logic [1:0]         w_hs2;
    logic               w_d;
    logic               w_br_next;
    logic               w_last;

    assign w_hs1     = half_sub_nand(r_a[0], r_b[0]);
    assign w_hs2     = half_sub_nand(w_hs1[0], r_br);
    assign w_d       = w_hs2[0];
    assign w_br_next = nand2(nand2(w_hs1[1], w_hs1[1]), nand2(w_hs2[1], w_hs2[1]));
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand shift registers, running borrow, bit counter and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= {WIDTH{1'b0}};
            r_b    <= {WIDTH{1'b0}};
            r_res  <= {WIDTH{1'b0}};
            r_br   <= 1'b0;
            r_cnt  <= {CNT_W{1'b0}};
            r_diff <= {WIDTH{1'b0}};
            r_bo   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_br  <= borrow_in;
                        r_cnt <= {CNT_W{1'b0}};
                    end
                end
                S_RUN: begin
                    r_a   <= {1'b0, r_a[WIDTH-1:1]};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_res <= {w_d, r_res[WIDTH-1:1]};
                    r_br  <= w_br_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    // The final bit lands straight in the visible result on the DONE-entry edge.
                    if (w_last) begin
                        r_diff <= {w_d, r_res[WIDTH-1:1]};
                        r_bo   <= w_br_next;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Registered handshake outputs, derived from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_next != S_IDLE);
            r_done <= (w_state_next == S_DONE);
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_bo;

endmodule

// File: tb/tb_serial_half_sub_nand.sv
// Directed self-checking bench for serial_half_sub_nand (WIDTH=4).
module tb_serial_half_sub_nand;
    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
    } vec_t;

    vec_t vecs[10];

    serial_half_sub_nand #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One full operation with cycle-exact latency and busy/done checks.
    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin,
                          input logic [W-1:0] ed, input logic ebo, input bit full);
        @(negedge clk);
        a = va; b = vb; borrow_in = vbin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (full) chk("busy_after_load", busy, 1);
        for (int i = 1; i <= W; i++) begin
            @(posedge clk); #1;
            if (i < W) begin
                if (full) chk("done_early", done, 0);
            end else begin
                chk("done_at_k+W", done, 1);
                chk("diff", diff, ed);
                chk("borrow_out", borrow_out, ebo);
            end
        end
        @(posedge clk); #1;
        chk("done_pulse_end", done, 0);
        if (full) begin
            chk("busy_end", busy, 0);
            chk("diff_hold", diff, ed);
        end
    endtask

    initial begin
        logic [W:0] ref5;
        int         dones;
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;

        vecs[0] = '{4'd1,  4'd0,  1'b0, 4'd1,  1'b0};
        vecs[1] = '{4'd0,  4'd1,  1'b0, 4'd15, 1'b1};
        vecs[2] = '{4'd1,  4'd1,  1'b0, 4'd0,  1'b0};
        vecs[3] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1};
        vecs[4] = '{4'd9,  4'd3,  1'b0, 4'd6,  1'b0};
        vecs[5] = '{4'd2,  4'd5,  1'b0, 4'd13, 1'b1};
        vecs[6] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
        vecs[7] = '{4'd8,  4'd1,  1'b1, 4'd6,  1'b0};
        vecs[8] = '{4'd0,  4'd15, 1'b0, 4'd1,  1'b1};
        vecs[9] = '{4'd15, 4'd0,  1'b0, 4'd15, 1'b0};

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bo", borrow_out, 0);
        @(negedge clk); rst_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo, 1'b1);

        // Reset mid-RUN clears outputs immediately; no spurious done afterwards.
        @(negedge clk); a = 4'd9; b = 4'd3; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); rst_n = 1'b0; #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_diff", diff, 0);
        chk("mid_rst_bo", borrow_out, 0);
        @(negedge clk); rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        chk("no_done_after_rst", dones, 0);
        run_op(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1);

        // Handshake: starts during RUN/DONE ignored, held start loads on first IDLE edge.
        @(negedge clk); a = 4'd9; b = 4'd3; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 4'd15; b = 4'd15;
        for (int e = 1; e <= 11; e++) begin
            @(negedge clk);
            start = (e == 1) || (e == 3) || (e >= 4 && e <= 6);
            @(posedge clk); #1;
            chk($sformatf("hs_done_e%0d", e), done, (e == 4 || e == 10) ? 1 : 0);
            chk($sformatf("hs_busy_e%0d", e), busy, (e == 5 || e == 11) ? 0 : 1);
            if (e == 4) chk("hs_diff1", diff, 6);
            if (e == 10) begin
                chk("hs_diff2", diff, 0);
                chk("hs_bo2", borrow_out, 0);
            end
        end
        @(negedge clk); start = 1'b0;

        // Exhaustive sweep against an independent 5-bit arithmetic reference.
        dones = 0;
        for (int v = 0; v < 512; v++) begin
            ref5 = {1'b0, v[7:4]} - {1'b0, v[3:0]} - {4'b0, v[8]};
            @(negedge clk);
            a = v[7:4]; b = v[3:0]; borrow_in = v[8]; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
            for (int c = 0; c < W + 1; c++) begin
                @(posedge clk); #1;
                if (done === 1'b1) begin
                    dones++;
                    if (diff !== ref5[W-1:0] || borrow_out !== ref5[W]) begin
                        chk($sformatf("ex_%0d_%0d_%0d", v[7:4], v[3:0], v[8]),
                            {borrow_out, diff}, ref5);
                    end
                end
            end
        end
        chk("ex_done_count", dones, 512);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
